// File: rtl/layer24_train_sequencer_pkg.sv
// Shared types for the 24-neuron layer sequencer: layer value type, FSM
// state encoding and the absolute-difference helper used for the error sum.
package layer24_train_sequencer_pkg;

  typedef logic [7:0]         zero2one_t;
  typedef logic signed [15:0] frac_t;

  localparam int ZW          = $bits(zero2one_t);
  localparam int LAYER_WIDTH = 24;
  localparam int ERR_W       = ZW + 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    INFER  = 3'd2,
    LEARN  = 3'd3,
    REPORT = 3'd4
  } seq_state_t;

  function automatic zero2one_t zero2one_absdiff(input zero2one_t a, input zero2one_t b);
    return (a > b) ? zero2one_t'(a - b) : zero2one_t'(b - a);
  endfunction

endpackage

// File: rtl/layer24_train_sequencer_if.sv
// Sample stream, layer drive/capture and result stream of the sequencer.
// master = sequencer side, slave = environment (sample source, layer, result sink).
interface layer24_train_sequencer_if #(
  parameter int N = 16
);
  logic s_valid;
  logic s_ready;
  logic s_train;
  layer24_train_sequencer_pkg::zero2one_t [N-1:0] s_in;
  layer24_train_sequencer_pkg::zero2one_t [layer24_train_sequencer_pkg::LAYER_WIDTH-1:0] s_expected;

  layer24_train_sequencer_pkg::zero2one_t [N-1:0] layer_in;
  logic layer_valid;
  logic layer_learn;
  layer24_train_sequencer_pkg::zero2one_t [layer24_train_sequencer_pkg::LAYER_WIDTH-1:0] layer_expected_out;
  layer24_train_sequencer_pkg::zero2one_t [layer24_train_sequencer_pkg::LAYER_WIDTH-1:0] layer_out;

  logic r_valid;
  logic r_ready;
  layer24_train_sequencer_pkg::zero2one_t [layer24_train_sequencer_pkg::LAYER_WIDTH-1:0] r_out;
  logic [layer24_train_sequencer_pkg::ERR_W-1:0] r_error;

  logic [31:0] sample_count;
  logic        busy;

  modport master (
    input  s_valid, s_train, s_in, s_expected, layer_out, r_ready,
    output s_ready, layer_in, layer_valid, layer_learn, layer_expected_out,
           r_valid, r_out, r_error, sample_count, busy
  );

  modport slave (
    output s_valid, s_train, s_in, s_expected, layer_out, r_ready,
    input  s_ready, layer_in, layer_valid, layer_learn, layer_expected_out,
           r_valid, r_out, r_error, sample_count, busy
  );

endinterface

// File: rtl/layer24_train_sequencer_sample_fifo.sv
// Small circular FIFO holding packed {train, in, expected} sample words.
// Occupancy is registered so full/empty never depend on this cycle's push/pop.
module sample_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/layer24_train_sequencer.sv
// Upstream driver for the 24-neuron learning layer: buffers samples, runs the
// inference and optional learn phases, and reports captured outputs plus |error| sum.
module layer24_train_sequencer
  import layer24_train_sequencer_pkg::*;
#(
  parameter int N            = 16,
  parameter int DEPTH        = 2,
  parameter int INFER_CYCLES = 2,
  parameter int LEARN_CYCLES = 1
) (
  input logic                       clock,
  input logic                       reset,
  layer24_train_sequencer_if.master bus
);

  localparam int WORD_W = 1 + (N + LAYER_WIDTH) * ZW;
  localparam int PH_W   = 16;

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_LOAD   = 3'(LOAD);
  localparam logic [2:0] ST_INFER  = 3'(INFER);
  localparam logic [2:0] ST_LEARN  = 3'(LEARN);
  localparam logic [2:0] ST_REPORT = 3'(REPORT);

  logic [2:0]                     state_q, state_d;
  logic [PH_W-1:0]                phase_q, phase_d;
  logic                           work_train_q, work_train_d;
  zero2one_t [N-1:0]              work_in_q, work_in_d;
  zero2one_t [LAYER_WIDTH-1:0]    work_exp_q, work_exp_d;
  zero2one_t [LAYER_WIDTH-1:0]    r_out_q, r_out_d;
  logic [ERR_W-1:0]               r_error_q, r_error_d;
  logic [31:0]                    count_q, count_d;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [WORD_W-1:0] fifo_wdata, fifo_rdata;

  function automatic logic [ERR_W-1:0] abs_err_sum(
    input zero2one_t [LAYER_WIDTH-1:0] got,
    input zero2one_t [LAYER_WIDTH-1:0] tgt
  );
    logic [ERR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LAYER_WIDTH; i++) begin
      acc = acc + ERR_W'(zero2one_absdiff(got[i], tgt[i]));
    end
    return acc;
  endfunction

  assign fifo_push  = bus.s_valid && !fifo_full;
  assign fifo_wdata = {bus.s_train, bus.s_in, bus.s_expected};

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    work_train_d = work_train_q;
    work_in_d    = work_in_q;
    work_exp_d   = work_exp_q;
    r_out_d      = r_out_q;
    r_error_d    = r_error_q;
    count_d      = count_q;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {work_train_d, work_in_d, work_exp_d} = fifo_rdata;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        phase_d = '0;
        state_d = ST_INFER;
      end
      ST_INFER: begin
        if (phase_q == PH_W'(INFER_CYCLES - 1)) begin
          r_out_d = bus.layer_out;
          phase_d = '0;
          state_d = work_train_q ? ST_LEARN : ST_REPORT;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      // r_out is not touched here: the result reports the pre-learn response
      ST_LEARN: begin
        if (phase_q == PH_W'(LEARN_CYCLES - 1)) begin
          phase_d = '0;
          state_d = ST_REPORT;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_REPORT: begin
        if (bus.r_ready) begin
          count_d = count_q + 32'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Error is latched once, on entry to REPORT, from the value being captured
    if (state_d == ST_REPORT && state_q != ST_REPORT) begin
      r_error_d = abs_err_sum(r_out_d, work_exp_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      work_train_q <= 1'b0;
      work_in_q    <= '0;
      work_exp_q   <= '0;
      r_out_q      <= '0;
      r_error_q    <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      work_train_q <= work_train_d;
      work_in_q    <= work_in_d;
      work_exp_q   <= work_exp_d;
      r_out_q      <= r_out_d;
      r_error_q    <= r_error_d;
      count_q      <= count_d;
    end
  end

  assign bus.s_ready            = !fifo_full;
  assign bus.layer_in           = work_in_q;
  assign bus.layer_expected_out = work_exp_q;
  assign bus.layer_valid        = (state_q == ST_INFER) || (state_q == ST_LEARN);
  assign bus.layer_learn        = (state_q == ST_LEARN);
  assign bus.r_valid            = (state_q == ST_REPORT);
  assign bus.r_out              = r_out_q;
  assign bus.r_error            = r_error_q;
  assign bus.sample_count       = count_q;
  assign bus.busy               = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_layer24_train_sequencer.sv
// Bench for layer24_train_sequencer: directed vector table, multi-cycle corner
// sequences, and a randomized run scored against a sample-level reference model.
module tb_layer24_train_sequencer;
  import layer24_train_sequencer_pkg::*;

  localparam int N       = 16;
  localparam int DEPTH   = 2;
  localparam int INFER_C = 2;
  localparam int LEARN_C = 1;
  localparam int NR      = 200;

  typedef zero2one_t [N-1:0]           vecn_t;
  typedef zero2one_t [LAYER_WIDTH-1:0] vec24_t;

  typedef struct {
    bit        train;
    zero2one_t in_fill;
    zero2one_t exp_a;
    zero2one_t exp_b;
    int        lmode;
    int        exp_err;
    int        exp_lat;
    int        exp_vld;
    int        exp_lrn;
  } vec_t;

  typedef struct {
    bit     tr;
    vecn_t  din;
    vec24_t tgt;
  } smp_t;

  logic clock = 1'b0;
  logic reset;
  logic reset2;
  always #5 clock = ~clock;

  layer24_train_sequencer_if #(.N(N)) bus ();
  layer24_train_sequencer_if #(.N(N)) bus2 ();

  layer24_train_sequencer #(
    .N(N), .DEPTH(DEPTH), .INFER_CYCLES(INFER_C), .LEARN_CYCLES(LEARN_C)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  layer24_train_sequencer #(
    .N(N), .DEPTH(DEPTH), .INFER_CYCLES(INFER_C), .LEARN_CYCLES(3)
  ) dut_l3 (
    .clock (clock),
    .reset (reset2),
    .bus   (bus2)
  );

  // Layer stand-in: 0 = echo target, 1 = all zero, 2 = function of the input
  // that changes during learn (so a late capture would be visible)
  int     lmode;
  vec24_t lo;

  function automatic zero2one_t fo(input int i, input vecn_t d);
    return d[i % N] ^ zero2one_t'(i * 37 + 5);
  endfunction

  always_comb begin
    lo = '0;
    for (int i = 0; i < LAYER_WIDTH; i++) begin
      if (lmode == 0)      lo[i] = bus.layer_expected_out[i];
      else if (lmode == 2) lo[i] = bus.layer_learn ? ~fo(i, bus.layer_in) : fo(i, bus.layer_in);
    end
  end
  assign bus.layer_out  = lo;
  assign bus2.layer_out = '0;

  // Reference: what the result should hold for a sample, from the layer's
  // response during inference, and the summed absolute distance to the target
  function automatic vec24_t ref_out(input int mode, input vecn_t d, input vec24_t t);
    vec24_t o;
    for (int i = 0; i < LAYER_WIDTH; i++) begin
      if (mode == 0)      o[i] = t[i];
      else if (mode == 1) o[i] = '0;
      else                o[i] = fo(i, d);
    end
    return o;
  endfunction

  function automatic int ref_err(input vec24_t got, input vec24_t t);
    int s = 0;
    for (int i = 0; i < LAYER_WIDTH; i++) begin
      int diff;
      diff = int'(got[i]) - int'(t[i]);
      s += (diff < 0) ? -diff : diff;
    end
    return s;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_layer_valid"}, bus.layer_valid, 0);
    chk({tag, "_layer_learn"}, bus.layer_learn, 0);
    chk({tag, "_r_valid"}, bus.r_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_layer_in"}, bus.layer_in, 0);
    chk({tag, "_layer_exp"}, bus.layer_expected_out, 0);
    chk({tag, "_r_out"}, bus.r_out, 0);
    chk({tag, "_r_error"}, bus.r_error, 0);
    chk({tag, "_sample_count"}, bus.sample_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic push1(input bit tr, input vecn_t d, input vec24_t t);
    int g = 0;
    bus.s_valid = 1'b1; bus.s_train = tr; bus.s_in = d; bus.s_expected = t;
    while (!bus.s_ready && g < 200) begin
      @(posedge clock); #1; g++;
    end
    chk("push_ready", bus.s_ready, 1);
    @(posedge clock); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic gen(output bit tr, output vecn_t d, output vec24_t t);
    tr = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++)
      d[i] = ($urandom_range(0, 3) == 0) ? 8'hff : zero2one_t'($urandom);
    for (int i = 0; i < LAYER_WIDTH; i++)
      t[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : zero2one_t'($urandom);
  endtask

  vec_t   tbl [6];
  vecn_t  din;
  vec24_t tgt, eo;
  vecn_t  bb_in [3];
  vec24_t bb_tgt [3];
  bit     tr;
  int     k, vc, lc, fv, fl, g, done, ee;
  bit     seen;
  vec24_t snap_out;
  logic [ERR_W-1:0] snap_err;

  initial begin
    reset = 1'b1; reset2 = 1'b1; lmode = 0;
    bus.s_valid = 0; bus.s_train = 0; bus.s_in = '0; bus.s_expected = '0; bus.r_ready = 0;
    bus2.s_valid = 0; bus2.s_train = 0; bus2.s_in = '0; bus2.s_expected = '0; bus2.r_ready = 1;

    tbl[0] = '{0, 8'hff, 8'h3c, 8'hc3, 0, 0,    4, 2, 0};
    tbl[1] = '{1, 8'h00, 8'hff, 8'hff, 1, 6120, 5, 3, 1};
    tbl[2] = '{0, 8'h55, 8'h10, 8'h10, 1, 384,  4, 2, 0};
    tbl[3] = '{1, 8'haa, 8'h00, 8'hff, 1, 3060, 5, 3, 1};
    tbl[4] = '{1, 8'h0f, 8'h20, 8'h20, 2, -1,   5, 3, 1};
    tbl[5] = '{0, 8'hf0, 8'h7f, 8'h80, 2, -1,   4, 2, 0};

    repeat (3) @(posedge clock);
    #1; reset = 1'b0;
    chk_reset_state("rst0");

    // Directed vectors, one sample at a time with the consumer always ready
    done = 0;
    bus.r_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) din[i] = tbl[r].in_fill;
      for (int i = 0; i < LAYER_WIDTH; i++) tgt[i] = (i % 2 == 0) ? tbl[r].exp_a : tbl[r].exp_b;
      lmode = tbl[r].lmode;
      push1(tbl[r].train, din, tgt);
      k = 0; vc = 0; lc = 0; fv = -1; fl = -1; seen = 0;
      while (k < 40 && !seen) begin
        @(posedge clock); #1; k++;
        if (bus.layer_valid) begin vc++; if (fv < 0) fv = k; end
        if (bus.layer_learn) begin lc++; if (fl < 0) fl = k; end
        if (bus.r_valid) seen = 1;
      end
      chk("vec_rvalid_seen", seen, 1);
      chk("vec_latency", k, tbl[r].exp_lat);
      chk("vec_valid_cycles", vc, tbl[r].exp_vld);
      chk("vec_learn_cycles", lc, tbl[r].exp_lrn);
      if (tbl[r].train) chk("vec_learn_after_infer", fl - fv, INFER_C);
      eo = ref_out(tbl[r].lmode, din, tgt);
      ee = (tbl[r].exp_err >= 0) ? tbl[r].exp_err : ref_err(eo, tgt);
      chk("vec_r_out", bus.r_out, eo);
      chk("vec_r_error", bus.r_error, ee);
      chk("vec_layer_in", bus.layer_in, din);
      chk("vec_layer_exp", bus.layer_expected_out, tgt);
      @(posedge clock); #1;
      chk("vec_r_valid_fall", bus.r_valid, 0);
      chk("vec_sample_count", bus.sample_count, done + 1);
      chk("vec_busy_idle", bus.busy, 0);
      done++;
    end

    do_reset();
    chk_reset_state("rst1");

    // Three back-to-back pushes with the result side stalled
    lmode = 2;
    bus.r_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      gen(tr, bb_in[j], bb_tgt[j]);
      push1(1'b0, bb_in[j], bb_tgt[j]);
    end
    chk("bb_s_ready_low", bus.s_ready, 0);
    chk("bb_busy", bus.busy, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("bb_s_ready_still_low", bus.s_ready, 0);
    bus.r_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      g = 0;
      while (!bus.r_valid && g < 50) begin @(posedge clock); #1; g++; end
      chk("bb_rvalid_seen", bus.r_valid, 1);
      eo = ref_out(2, bb_in[j], bb_tgt[j]);
      chk("bb_r_out_order", bus.r_out, eo);
      chk("bb_r_error", bus.r_error, ref_err(eo, bb_tgt[j]));
      @(posedge clock); #1;
      chk("bb_sample_count", bus.sample_count, j + 1);
    end

    // Stalled result must hold, then complete exactly once
    do_reset();
    bus.r_ready = 1'b0;
    gen(tr, din, tgt);
    push1(1'b1, din, tgt);
    g = 0;
    while (!bus.r_valid && g < 50) begin @(posedge clock); #1; g++; end
    chk("hold_rvalid_seen", bus.r_valid, 1);
    snap_out = bus.r_out; snap_err = bus.r_error;
    eo = ref_out(2, din, tgt);
    chk("hold_r_out_ref", snap_out, eo);
    chk("hold_r_error_ref", snap_err, ref_err(eo, tgt));
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk("hold_r_valid", bus.r_valid, 1);
      chk("hold_r_out", bus.r_out, snap_out);
      chk("hold_r_error", bus.r_error, snap_err);
    end
    bus.r_ready = 1'b1;
    @(posedge clock); #1;
    bus.r_ready = 1'b0;
    chk("hold_r_valid_fall", bus.r_valid, 0);
    chk("hold_count", bus.sample_count, 1);
    for (int c = 0; c < 6; c++) begin
      bus.r_ready = ~bus.r_ready;
      @(posedge clock); #1;
    end
    chk("hold_one_completion", bus.sample_count, 1);
    chk("hold_busy", bus.busy, 0);

    // Reset on the second learn cycle of the LEARN_CYCLES=3 instance
    reset2 = 1'b1;
    @(posedge clock); #1;
    reset2 = 1'b0;
    gen(tr, din, tgt);
    bus2.s_valid = 1'b1; bus2.s_train = 1'b1; bus2.s_in = din; bus2.s_expected = tgt;
    @(posedge clock); #1;
    bus2.s_valid = 1'b0;
    g = 0;
    while (!bus2.layer_learn && g < 20) begin @(posedge clock); #1; g++; end
    chk("l3_learn_seen", bus2.layer_learn, 1);
    @(posedge clock); #1;
    chk("l3_learn_2nd_cycle", bus2.layer_learn, 1);
    reset2 = 1'b1;
    @(posedge clock); #1;
    reset2 = 1'b0;
    chk("l3_valid_low", bus2.layer_valid, 0);
    chk("l3_learn_low", bus2.layer_learn, 0);
    chk("l3_r_valid_low", bus2.r_valid, 0);
    chk("l3_fifo_empty", bus2.busy, 0);
    chk("l3_count", bus2.sample_count, 0);
    chk("l3_s_ready", bus2.s_ready, 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (bus2.r_valid || bus2.layer_valid) seen = 1;
    end
    chk("l3_no_result", seen, 0);

    // Randomized traffic against the sample-level scoreboard
    do_reset();
    lmode = 2;
    fork
      begin : drv
        int  sent, cyc;
        bit  acc;
        sent = 0; cyc = 0;
        bus.s_valid = 1'b0;
        while (sent < NR && cyc < 20000) begin
          bus.r_ready = ($urandom_range(0, 2) == 0);
          if (!bus.s_valid && $urandom_range(0, 3) != 0) begin
            gen(tr, din, tgt);
            bus.s_train = tr; bus.s_in = din; bus.s_expected = tgt;
            bus.s_valid = 1'b1;
          end
          acc = bus.s_valid && bus.s_ready;
          @(posedge clock); #1; cyc++;
          if (acc) begin sent++; bus.s_valid = 1'b0; end
        end
        bus.s_valid = 1'b0;
        bus.r_ready = 1'b1;
      end
      begin : mon
        smp_t   q[$];
        smp_t   s, h;
        int     compl, mc, viol, full_cyc;
        bit     prev_stall;
        vec24_t prev_out, m_eo;
        logic [ERR_W-1:0] prev_err;
        compl = 0; mc = 0; viol = 0; full_cyc = 0; prev_stall = 0;
        prev_out = '0; prev_err = '0;
        while (compl < NR && mc < 40000) begin
          @(negedge clock); mc++;
          if (bus.layer_learn && !bus.layer_valid) viol++;
          if (!bus.s_ready) full_cyc++;
          if (prev_stall) begin
            chk("rnd_hold_r_valid", bus.r_valid, 1);
            chk("rnd_hold_r_out", bus.r_out, prev_out);
            chk("rnd_hold_r_error", bus.r_error, prev_err);
          end
          if (bus.s_valid && bus.s_ready) begin
            s.tr = bus.s_train; s.din = bus.s_in; s.tgt = bus.s_expected;
            q.push_back(s);
          end
          if (bus.r_valid && bus.r_ready) begin
            chk("rnd_queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
              h = q.pop_front();
              m_eo = ref_out(2, h.din, h.tgt);
              chk("rnd_r_out", bus.r_out, m_eo);
              chk("rnd_r_error", bus.r_error, ref_err(m_eo, h.tgt));
            end
            chk("rnd_sample_count", bus.sample_count, compl);
            compl++;
          end
          prev_stall = bus.r_valid && !bus.r_ready;
          prev_out   = bus.r_out;
          prev_err   = bus.r_error;
        end
        chk("rnd_completions", compl, NR);
        chk("rnd_queue_drained", q.size(), 0);
        chk("rnd_learn_implies_valid", viol, 0);
        chk("rnd_s_ready_dropped", full_cyc > 0, 1);
      end
    join
    @(posedge clock); #1;
    chk("rnd_final_count", bus.sample_count, NR);
    chk("rnd_final_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
